// File: rtl/echo_pkg.sv
// Shared types and helpers for the multichannel echo core: FSM state
// encoding, coefficient format constants and a saturating adder.
package echo_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RD,
        S_WT,
        S_CALC,
        S_WR,
        S_DONE
    } state_t;

    // Coefficients are unsigned Q0.8: gain = coef / 256.
    localparam int COEF_W     = 8;
    localparam int COEF_SHIFT = 8;

    // Add two sign-extended operands and clamp the sum to a w-bit signed range.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int                 w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/multichannel_echo_ram.sv
// Simple dual-port delay-line memory: one write port, one read port with a
// single cycle of registered read latency. Shared by all echo channels.
module multichannel_echo_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 8192,
    parameter int ADDR_W = 13
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic signed [W-1:0]      wdata,
    input  logic [ADDR_W-1:0]        raddr,
    output logic signed [W-1:0]      rdata
);

    logic signed [W-1:0] mem [0:DEPTH-1];
    logic signed [W-1:0] rdata_q;

    // Write port and registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/multichannel_echo.sv
// N-channel echo/delay core. One shared delay RAM; on each accepted strobe
// the FSM walks channels 0..N_CH-1 doing read tap -> mix -> write feedback,
// then publishes all outputs together and advances the write pointer.
// Optional build macro MULTICHANNEL_ECHO_CLEAR_EN: zero the whole delay
// memory after every reset before accepting strobes.
module multichannel_echo
    import echo_pkg::*;
#(
    parameter int  W        = 16,
    parameter int  ECHO_LEN = 4096,
    parameter int  N_CH     = 2,
    localparam int AW       = $clog2(ECHO_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  strobe,
    input  logic signed [W-1:0]   sample_in0,
    input  logic signed [W-1:0]   sample_in1,
    input  logic signed [W-1:0]   sample_in2,
    input  logic signed [W-1:0]   sample_in3,
    output logic signed [W-1:0]   sample_out0,
    output logic signed [W-1:0]   sample_out1,
    output logic signed [W-1:0]   sample_out2,
    output logic signed [W-1:0]   sample_out3,
    input  logic [AW-1:0]         delay_len,
    input  logic [COEF_W-1:0]     fb_coef,
    input  logic [COEF_W-1:0]     mix_coef,
    output logic                  busy,
    output logic                  overrun,
    input  logic [7:0]            jack
);

    localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int RAW   = AW + CW;
    localparam int DEPTH = N_CH * ECHO_LEN;
    localparam int PW    = W + COEF_W + 1;
    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         ch_q, ch_d;
    logic [AW-1:0]         wptr_q, wptr_d;
    logic                  overrun_q, overrun_d;
    logic signed [W-1:0]   out_q [4];
    logic signed [W-1:0]   out_d [4];
    logic signed [W-1:0]   in_q [4];
    logic signed [W-1:0]   in_d [4];
    logic signed [W-1:0]   wet_q [4];
    logic signed [W-1:0]   wet_d [4];
    logic [AW-1:0]         delay_q, delay_d;
    logic [COEF_W-1:0]     fb_q, fb_d;
    logic [COEF_W-1:0]     mix_q, mix_d;
    logic signed [W-1:0]   d_q, d_d;
    logic signed [W-1:0]   fbk_q, fbk_d;

    logic signed [W-1:0]   in_bus [4];
    logic signed [W-1:0]   in_cur;
    logic signed [PW-1:0]  prod_mix;
    logic signed [PW-1:0]  prod_fb;
    logic signed [W-1:0]   wet_calc;
    logic signed [W-1:0]   fbk_calc;

    logic                  we;
    logic [RAW-1:0]        waddr;
    logic [RAW-1:0]        raddr;
    logic signed [W-1:0]   wdata;
    logic signed [W-1:0]   rdata;

`ifdef MULTICHANNEL_ECHO_CLEAR_EN
    localparam logic [RAW-1:0] LAST_ADDR = RAW'(DEPTH - 1);
    logic [RAW-1:0]        clr_q, clr_d;
`endif

    // Jack detect is part of the drop-in port set but carries no function here.
    logic unused_jack;
    assign unused_jack = ^jack;

    assign in_bus[0] = sample_in0;
    assign in_bus[1] = sample_in1;
    assign in_bus[2] = sample_in2;
    assign in_bus[3] = sample_in3;

    assign sample_out0 = out_q[0];
    assign sample_out1 = out_q[1];
    assign sample_out2 = out_q[2];
    assign sample_out3 = out_q[3];

    // busy drops while reset is held so every output reads 0 during reset.
    assign busy    = rst & (state_q != S_IDLE);
    assign overrun = overrun_q;

    // Wet and feedback values for the channel currently being visited
    always_comb begin
        in_cur = in_q[0];
        for (int c = 1; c < 4; c++) begin
            if (c < N_CH && ch_q == CW'(c)) begin
                in_cur = in_q[c];
            end
        end
        prod_mix = PW'(d_q) * PW'($signed({1'b0, mix_q}));
        prod_fb  = PW'(d_q) * PW'($signed({1'b0, fb_q}));
        wet_calc = W'(sat_add(64'(in_cur), 64'(prod_mix >>> COEF_SHIFT), W));
        fbk_calc = W'(sat_add(64'(in_cur), 64'(prod_fb >>> COEF_SHIFT), W));
    end

    // Next-state, datapath updates and RAM port control
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        wptr_d    = wptr_q;
        overrun_d = overrun_q | (strobe & (state_q != S_IDLE));
        out_d     = out_q;
        in_d      = in_q;
        wet_d     = wet_q;
        delay_d   = delay_q;
        fb_d      = fb_q;
        mix_d     = mix_q;
        d_d       = d_q;
        fbk_d     = fbk_q;
        we        = 1'b0;
        waddr     = {ch_q, wptr_q};
        wdata     = fbk_q;
        raddr     = {ch_q, AW'(wptr_q - delay_q)};
`ifdef MULTICHANNEL_ECHO_CLEAR_EN
        clr_d     = clr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    in_d    = in_bus;
                    delay_d = delay_len;
                    fb_d    = fb_coef;
                    mix_d   = mix_coef;
                    ch_d    = '0;
                    state_d = S_RD;
                end
            end
`ifdef MULTICHANNEL_ECHO_CLEAR_EN
            S_CLEAR: begin
                we    = 1'b1;
                waddr = clr_q;
                wdata = '0;
                if (clr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end else begin
                    clr_d = clr_q + RAW'(1);
                end
            end
`endif
            S_RD: begin
                state_d = S_WT;
            end
            S_WT: begin
                d_d     = rdata;
                state_d = S_CALC;
            end
            S_CALC: begin
                fbk_d = fbk_calc;
                for (int c = 0; c < 4; c++) begin
                    if (c < N_CH && ch_q == CW'(c)) begin
                        wet_d[c] = wet_calc;
                    end
                end
                state_d = S_WR;
            end
            S_WR: begin
                we = 1'b1;
                if (ch_q == LAST_CH) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CW'(1);
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                for (int c = 0; c < 4; c++) begin
                    out_d[c] = (c < N_CH) ? wet_q[c] : in_q[c];
                end
                wptr_d  = wptr_q + AW'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and published outputs; reset abandons any pass in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
`ifdef MULTICHANNEL_ECHO_CLEAR_EN
            state_q <= S_CLEAR;
            clr_q   <= '0;
`else
            state_q <= S_IDLE;
`endif
            ch_q      <= '0;
            wptr_q    <= '0;
            overrun_q <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                out_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            wptr_q    <= wptr_d;
            overrun_q <= overrun_d;
            out_q     <= out_d;
`ifdef MULTICHANNEL_ECHO_CLEAR_EN
            clr_q     <= clr_d;
`endif
        end
    end

    // Per-pass captured operands and intermediates; meaningful only inside a pass
    always_ff @(posedge clk) begin
        in_q    <= in_d;
        wet_q   <= wet_d;
        delay_q <= delay_d;
        fb_q    <= fb_d;
        mix_q   <= mix_d;
        d_q     <= d_d;
        fbk_q   <= fbk_d;
    end

    multichannel_echo_ram #(
        .W      (W),
        .DEPTH  (DEPTH),
        .ADDR_W (RAW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_multichannel_echo.sv
// Testbench for multichannel_echo (ECHO_LEN=16, N_CH=2) with a per-channel
// circular-buffer reference model.
module tb_multichannel_echo;

    localparam int W   = 16;
    localparam int LEN = 16;
    localparam int NCH = 2;
    localparam int AW  = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                strobe = 1'b0;
    logic signed [W-1:0] sample_in0, sample_in1, sample_in2, sample_in3;
    logic signed [W-1:0] sample_out0, sample_out1, sample_out2, sample_out3;
    logic [AW-1:0]       delay_len;
    logic [7:0]          fb_coef, mix_coef, jack;
    logic                busy, overrun;

    int n_pass   = 0;
    int n_checks = 0;

    int mem_m [NCH][LEN];
    int wp_m;
    int out_m [4];

    always #5 clk = ~clk;

    multichannel_echo #(.W(W), .ECHO_LEN(LEN), .N_CH(NCH)) dut (
        .clk(clk), .rst(rst), .strobe(strobe),
        .sample_in0(sample_in0), .sample_in1(sample_in1),
        .sample_in2(sample_in2), .sample_in3(sample_in3),
        .sample_out0(sample_out0), .sample_out1(sample_out1),
        .sample_out2(sample_out2), .sample_out3(sample_out3),
        .delay_len(delay_len), .fb_coef(fb_coef), .mix_coef(mix_coef),
        .busy(busy), .overrun(overrun), .jack(jack)
    );

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        wp_m = 0;
        for (int c = 0; c < 4; c++) out_m[c] = 0;
`ifdef MULTICHANNEL_ECHO_CLEAR_EN
        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < LEN; a++) mem_m[c][a] = 0;
`endif
    endtask

    // One sample period of an N-channel echo: each channel reads the sample
    // stored dl periods ago (dl=0 means LEN), outputs in + mix*tap and stores
    // in + fb*tap in the current slot.
    task automatic model_pass(input int i0, input int i1, input int i2, input int i3,
                              input int dl, input int fb, input int mix);
        int iv [4];
        iv = '{i0, i1, i2, i3};
        for (int c = 0; c < 4; c++) begin
            if (c < NCH) begin
                int tap;
                tap = mem_m[c][(wp_m - dl) & (LEN - 1)];
                out_m[c] = sat16(iv[c] + ((tap * mix) >>> 8));
                mem_m[c][wp_m] = sat16(iv[c] + ((tap * fb) >>> 8));
            end else begin
                out_m[c] = iv[c];
            end
        end
        wp_m = (wp_m + 1) % LEN;
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_o0"}, sample_out0, out_m[0]);
        check({tag, "_o1"}, sample_out1, out_m[1]);
        check({tag, "_o2"}, sample_out2, out_m[2]);
        check({tag, "_o3"}, sample_out3, out_m[3]);
    endtask

    // Issue one strobe, scramble inputs after acceptance, optionally fire an
    // extra strobe extra_at cycles after acceptance, and check timing/outputs.
    task automatic run_pass(input int i0, input int i1, input int i2, input int i3,
                            input int dl, input int fb, input int mix, input int extra_at);
        int prev0;
        sample_in0 = W'(i0);
        sample_in1 = W'(i1);
        sample_in2 = W'(i2);
        sample_in3 = W'(i3);
        delay_len  = AW'(dl);
        fb_coef    = 8'(fb);
        mix_coef   = 8'(mix);
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        sample_in0 = W'($urandom);
        sample_in1 = W'($urandom);
        sample_in2 = W'($urandom);
        sample_in3 = W'($urandom);
        delay_len  = AW'($urandom);
        fb_coef    = 8'($urandom);
        mix_coef   = 8'($urandom);
        check("busy_acc", busy, 1);
        prev0 = out_m[0];
        model_pass(i0, i1, i2, i3, dl, fb, mix);
        for (int k = 1; k <= 9; k++) begin
            if (k == extra_at) strobe = 1'b1;
            tick();
            strobe = 1'b0;
            if (k == 8) begin
                check("hold_o0", sample_out0, prev0);
                check("busy_done", busy, 1);
            end
        end
        check("busy_end", busy, 0);
        check_outs("pass");
    endtask

    task automatic reset_dut(input int hold);
        int cnt;
        int exp_clear;
`ifdef MULTICHANNEL_ECHO_CLEAR_EN
        exp_clear = NCH * LEN;
`else
        exp_clear = 0;
`endif
        rst = 1'b0;
        for (int k = 0; k < hold; k++) tick();
        check("rst_o0", sample_out0, 0);
        check("rst_o1", sample_out1, 0);
        check("rst_o2", sample_out2, 0);
        check("rst_o3", sample_out3, 0);
        check("rst_ovr", overrun, 0);
        check("rst_busy", busy, 0);
        model_reset();
        rst = 1'b1;
        #1;
        cnt = 0;
        while (busy && cnt < 200) begin
            tick();
            cnt++;
        end
        check("clear_len", cnt, exp_clear);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        jack = 8'hA5;
        sample_in0 = '0; sample_in1 = '0; sample_in2 = '0; sample_in3 = '0;
        delay_len = '0; fb_coef = '0; mix_coef = '0;
        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < LEN; a++) mem_m[c][a] = 0;
        tick();
        tick();
        reset_dut(2);
        check_outs("init");
        check("init_ovr", overrun, 0);

        // Impulse on channel 0, no feedback, half wet
        for (int t = 0; t < 6; t++) begin
            run_pass((t == 0) ? 16384 : 0, 0, 0, 0, 4, 0, 128, 0);
            if (t == 0) check("imp_t0", sample_out0, 16384);
            if (t == 4) check("imp_t4", sample_out0, 8192);
        end

        // Feedback impulse on channel 1
        for (int t = 0; t < 13; t++) begin
            run_pass(0, (t == 0) ? 16384 : 0, 0, 0, 4, 128, 128, 0);
            if (t % 4 == 0) check("fb_o1", sample_out1, 16384 >>> (t / 4));
            check("fb_o0", sample_out0, 0);
        end

        // Saturation both directions and negative echo
        for (int t = 0; t < 6; t++) begin
            run_pass(30000, 0, 0, 0, 1, 0, 255, 0);
            if (t >= 1) check("sat_pos", sample_out0, 32767);
        end
        for (int t = 0; t < 6; t++) begin
            run_pass(-30000, 0, 0, 0, 1, 0, 255, 0);
            if (t >= 1) check("sat_neg", sample_out0, -32768);
        end
        for (int t = 0; t < 20; t++) begin
            run_pass((t == 0) ? -16384 : 0, 0, 0, 0, 4, 0, 128, 0);
            if (t == 4) check("neg_echo", sample_out0, -8192);
        end

        // delay_len = 0 means a full-buffer delay; run past two wraps
        for (int t = 0; t < 40; t++) begin
            run_pass((t == 0) ? 16384 : 0, 0, 0, 0, 0, 0, 128, 0);
            check("wrap_o0", sample_out0, (t == 0) ? 16384 : ((t == 16) ? 8192 : 0));
        end

        // Overrun: strobe 3 cycles into a pass is dropped, flag is sticky
        check("ovr_pre", overrun, 0);
        run_pass(0, 0, 111, -222, 4, 0, 128, 3);
        check("ovr_set", overrun, 1);
        check("pass_o2", sample_out2, 111);
        check("pass_o3", sample_out3, -222);
        run_pass(5, 6, 7, 8, 4, 0, 128, 0);
        check("ovr_sticky", overrun, 1);

        // Randomised traffic against the model
        for (int n = 0; n < 60; n++) begin
            int gap;
            run_pass(int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, LEN - 1)),
                     int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), 0);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick();
        end

        // Reset in the middle of a pass (during the first CALC)
        sample_in0 = 16'sd16384; sample_in1 = 16'sd1000;
        sample_in2 = 16'sd5;     sample_in3 = 16'sd6;
        delay_len = 4'd4; fb_coef = 8'd128; mix_coef = 8'd128;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        tick();
        check("mid_busy", busy, 1);
        reset_dut(2);
        for (int t = 0; t < 20; t++) begin
            run_pass(0, 0, 0, 0, 4, 128, 128, 0);
`ifdef MULTICHANNEL_ECHO_CLEAR_EN
            check("clr_o0", sample_out0, 0);
            check("clr_o1", sample_out1, 0);
`endif
        end

        // Strobe landing in the DONE cycle is dropped too
        check("ovr_after_rst", overrun, 0);
        run_pass(1234, -1234, 9, -9, 3, 64, 200, 9);
        check("ovr_done", overrun, 1);
        run_pass(0, 0, 0, 0, 3, 64, 200, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multichannel_echo.md
Name: multichannel_echo

Overview:
- N-channel digital echo/delay with runtime delay length, per-block feedback and wet-mix gain.
- One BRAM is time-shared across all channels. A per-strobe FSM visits each channel in turn: read the delayed tap, mix, write back.
- Sits in the cores layer and drops in where a single-channel fixed echo core is used today, with the same 4-in/4-out sample port set.

Parameters:
- W, 16, sample width (signed)
- ECHO_LEN, 4096, per-channel buffer depth in samples; power of 2, at least 4
- N_CH, 2, processed channels, 1..4; channels at or above N_CH pass through
- AW, $clog2(ECHO_LEN), pointer width (derived localparam)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- strobe  in  1  one-cycle sample-rate tick
- sample_in0..3  in  W each  signed input samples
- sample_out0..3  out  W each  signed output samples
- delay_len  in  AW  echo delay in samples; 0 means ECHO_LEN
- fb_coef  in  8  feedback gain = fb_coef/256
- mix_coef  in  8  wet gain = mix_coef/256
- busy  out  1  FSM not in IDLE
- overrun  out  1  sticky: a strobe arrived while busy
- jack  in  8  jack-detect, unused

Behaviour:
- Reset (rst=0 at a clk edge):
  - all outputs 0, wptr=0, FSM to IDLE, overrun=0.
  - Applies mid-operation too: the pass is abandoned and no partial outputs are published.
- Memory: N_CH*ECHO_LEN words, address {ch, ptr}. One-cycle registered read latency.
- Sampling on strobe accept:
  - strobe in IDLE is accepted.
  - In that cycle, sample_in0..3, delay_len, fb_coef and mix_coef are captured; later changes do not affect the current pass.
- FSM, per channel ch = 0..N_CH-1:
  - IDLE -> RD (on accept): issue read at raddr = (wptr - delay_len) mod ECHO_LEN.
  - RD -> WT: wait for read data.
  - WT -> CALC: register d = delayed sample.
  - CALC -> WR: compute wet and fbk (below).
  - WR: write fbk to {ch, wptr}.
  - WR -> RD for ch+1, or WR -> DONE after the last channel.
- Arithmetic:
  - wet = sat(in + ((d*mix_coef) >>> 8)).
  - fbk = sat(in + ((d*fb_coef) >>> 8)).
  - Products are W+9 bits signed; the shift is arithmetic (floor); sat clamps to [-2^(W-1), 2^(W-1)-1].
- DONE:
  - all sample_out(ch<N_CH) update together from wet; sample_out(ch>=N_CH) take the captured inputs.
  - wptr increments, wrapping modulo ECHO_LEN.
  - Returns to IDLE.
  - Latency from strobe to output update is exactly 4*N_CH+1 cycles.
- Outputs hold their value between DONE pulses.
- delay_len=0: raddr=wptr, which reads the word written ECHO_LEN passes ago, so delay is ECHO_LEN.
- delay_len=D: echo appears D strobes after the input.
- Read-before-write: the same pass reads before it writes, so no collision.
- strobe while busy is dropped: overrun is set and held until reset.
- strobe in the DONE cycle counts as busy.
- Strobe period must be at least 4*N_CH+2 cycles for lossless operation.

Optional Feature:
- Macro: MULTICHANNEL_ECHO_CLEAR_EN.
- Defined:
  - after reset deasserts, FSM enters CLEAR and writes 0 to every address, 0..N_CH*ECHO_LEN-1, one per cycle.
  - busy is high throughout; strobes are dropped and set overrun.
  - Then goes to IDLE.
  - Reset during CLEAR restarts the clear.
- Undefined:
  - no CLEAR state; IDLE immediately after reset.
  - Memory content is undefined in hardware and zero-initialised in simulation.
  - The first ECHO_LEN passes may echo stale data.

Decomposition:
- Package echo_pkg:
  - FSM state enum (IDLE, CLEAR, RD, WT, CALC, WR, DONE)
  - COEF_W=8 and COEF_SHIFT=8 constants
  - parametrised saturating-add function
- Sub-module multichannel_echo_ram: simple dual-port, sync read, one write port, depth N_CH*ECHO_LEN, width W. Instantiated once.

Test Plan (ECHO_LEN=16, N_CH=2, CLEAR_EN defined unless noted):
- Impulse: delay_len=4, fb=0, mix=128, in0=16384 at strobe 0, then 0 -> out1 echo... out0 = 16384 at t0, 8192 at t4, 0 elsewhere; out ready exactly 9 cycles after each strobe.
- Feedback: delay_len=4, fb=128, mix=128, same impulse on in1 -> out1 = 16384, 8192, 4096, 2048 at t0, t4, t8, t12; in0 channel unaffected (0).
- Saturation and negatives: in0 held at 30000, delay_len=1, mix=255 -> out0 = 32767 from t1 onward; in0 held at -30000 -> -32768; -16384 impulse with mix=128 -> -8192 echo.
- Wrap and zero-length: delay_len=0, impulse at t0 -> echo at t16 only; run 40 strobes to confirm wptr wraps with no glitch.
- Overrun and passthrough: second strobe 3 cycles after the first -> ignored, overrun=1 and sticky; sample_in2/3 = 111/-222 appear unchanged on sample_out2/3.
- Reset mid-pass, then clear (CLEAR_EN): rst=0 during CALC -> outputs 0 and busy stays high for 32 cycles after release; earlier impulse history produces no echo.
